alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
Shares the single execute-stage ALU between two requesters: port 0 is the main pipeline, port 1 is the branch/address unit. It uses round-robin arbitration and latches the winner's operands and 4-bit ALU control code. It drives the external combinational ALU for one cycle, registers the result, and returns it to the owning requester over a valid/ready response handshake. Only one operation is in flight at a time.

Parameters:
XLEN, 32, operand/result width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_a  in  XLEN  operand A.
req0_b  in  XLEN  operand B.
req0_ctl  in  4  ALU code: 0000 and, 0001 or, 0010 add, 0110 sub.
rsp0_valid  out  1  result for requester 0 available.
rsp0_ready  in  1  requester 0 consumes result.
rsp0_data  out  XLEN  ALU result.
rsp0_zero  out  1  ALU zero flag.
rsp0_err  out  1  operation carried an illegal ctl code.
req1_valid, req1_ready, req1_a, req1_b, req1_ctl, rsp1_valid, rsp1_ready, rsp1_data, rsp1_zero, rsp1_err: same as port 0, for requester 1.
alu_a  out  XLEN  operand A to ALU.
alu_b  out  XLEN  operand B to ALU.
alu_ctl  out  4  control code to ALU.
alu_result  in  XLEN  ALU result, combinational from alu_a/alu_b/alu_ctl.
alu_zero  in  1  ALU zero flag.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset values: state IDLE; rr_last=1, so requester 0 wins the first tie; owner=0; operand/ctl/result/zero/err registers 0; all outputs 0.
- IDLE:
  - reqN_ready = reqN_valid AND grantN (combinational). Only one ready is high at a time.
  - Grant with a single requester valid: that requester wins.
  - Grant with both valid: the requester not equal to rr_last wins.
  - On accept: latch a, b, ctl and owner; set rr_last=owner; go to EXEC.
  - Illegal ctl (anything other than 0000/0001/0010/0110): latched as 0010; err register set to 1. Legal ctl clears err.
- EXEC (exactly 1 cycle): alu_a/alu_b/alu_ctl come from the latched registers. At the cycle end, capture alu_result and alu_zero, then go to RESP.
- alu_a/alu_b/alu_ctl always reflect the latched registers and hold their value outside EXEC.
- RESP:
  - rspN_valid=1 only for N=owner; rspN_data/zero/err come from the result registers and stay stable while valid.
  - On rsp_ready of the owner: go to IDLE; a new grant is possible in the next cycle.
  - A stall on rsp_ready holds RESP indefinitely; no request is accepted meanwhile.
  - rsp_ready of the non-owner is ignored.
  - rspN_data/zero/err read 0 when rspN_valid=0.
- Latency: accept at cycle T, rsp_valid high at T+2. Minimum issue interval is 3 cycles with rsp_ready held high.
- reqN_ready never asserts outside IDLE. A requester may hold valid across cycles, and its operands are sampled only on the accept cycle.
- req_valid deasserted before grant: no state change.
- Reset asserted mid-operation (EXEC or RESP): the operation is abandoned, no response is issued, and everything returns to reset values immediately (asynchronous).
- Arithmetic is done by the external ALU; the block performs no width extension and passes the XLEN bits through.

Test Plan:
- Single add: req0 a=5, b=7, ctl=0010 at T -> req0_ready at T; alu_ctl=0010 at T+1; rsp0_valid at T+2 with data=12, zero=0, err=0.
- Sub zero: req1 a=9, b=9, ctl=0110 -> rsp1_valid with data=0, zero=1; rsp0_valid stays 0 throughout.
- Contention: req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0, accepts at T, T+3, T+6, T+9.
- Response stall: rsp0_ready held 0 for 5 cycles with req1 valid -> rsp0 data stable, req1_ready stays 0 until the cycle after rsp0_ready=1.
- Illegal op: req0 ctl=1111, a=3, b=4 -> alu_ctl=0010, rsp0 data=7, rsp0_err=1; the following legal op returns err=0.
- Reset mid-EXEC: rst_n low during EXEC -> all outputs 0 immediately, no rsp_valid after release, and req0 wins the first tie.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external combinational ALU between the main pipeline
// (port 0) and the branch/address unit (port 1); one operation in flight at a time.

// Per-requester slice: ctl legality check, request ready and response gating.
module alu_share_port #(
  parameter int XLEN = 32
) (
  input  logic            idle,
  input  logic            win,
  input  logic            req_valid,
  input  logic [3:0]      req_ctl,
  output logic            req_ready,
  output logic [3:0]      ctl_norm,
  output logic            ctl_bad,
  input  logic            own_rsp,
  input  logic [XLEN-1:0] res,
  input  logic            res_zero,
  input  logic            res_err,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_zero,
  output logic            rsp_err
);
  always_comb begin
    ctl_bad   = !((req_ctl == 4'b0000) || (req_ctl == 4'b0001) ||
                  (req_ctl == 4'b0010) || (req_ctl == 4'b0110));
    // Illegal codes still execute, as an add, with the error flag carried along.
    ctl_norm  = ctl_bad ? 4'b0010 : req_ctl;
    req_ready = idle & win & req_valid;
    rsp_valid = own_rsp;
    rsp_data  = own_rsp ? res : '0;
    rsp_zero  = own_rsp & res_zero;
    rsp_err   = own_rsp & res_err;
  end
endmodule

module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [3:0]      req0_ctl,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_data,
  output logic            rsp0_zero,
  output logic            rsp0_err,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [3:0]      req1_ctl,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_data,
  output logic            rsp1_zero,
  output logic            rsp1_err,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);
  localparam int NREQ = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic            rr_last;
  logic            owner;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic [3:0]      ctl_q;
  logic            zero_q, err_q;

  logic [NREQ-1:0]           req_valid, req_ready, win, own_rsp, ctl_bad;
  logic [NREQ-1:0]           rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [NREQ-1:0][XLEN-1:0] req_a, req_b, rsp_data;
  logic [NREQ-1:0][3:0]      req_ctl, ctl_norm;

  logic idle, gnt, accept;

  assign req_valid = {req1_valid, req0_valid};
  assign req_a     = {req1_a, req0_a};
  assign req_b     = {req1_b, req0_b};
  assign req_ctl   = {req1_ctl, req0_ctl};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  assign idle   = (state == IDLE);
  // On a tie the requester that did not win last time gets the ALU.
  assign gnt    = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
  assign win    = gnt ? 2'b10 : 2'b01;
  assign accept = idle & (|req_valid);

  for (genvar i = 0; i < NREQ; i++) begin : g_port
    assign own_rsp[i] = (state == RESP) && (owner == 1'(i));
    alu_share_port #(.XLEN(XLEN)) u_port (
      .idle      (idle),
      .win       (win[i]),
      .req_valid (req_valid[i]),
      .req_ctl   (req_ctl[i]),
      .req_ready (req_ready[i]),
      .ctl_norm  (ctl_norm[i]),
      .ctl_bad   (ctl_bad[i]),
      .own_rsp   (own_rsp[i]),
      .res       (res_q),
      .res_zero  (zero_q),
      .res_err   (err_q),
      .rsp_valid (rsp_valid[i]),
      .rsp_data  (rsp_data[i]),
      .rsp_zero  (rsp_zero[i]),
      .rsp_err   (rsp_err[i])
    );
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_data  = rsp_data[0];
  assign rsp1_data  = rsp_data[1];
  assign rsp0_zero  = rsp_zero[0];
  assign rsp1_zero  = rsp_zero[1];
  assign rsp0_err   = rsp_err[0];
  assign rsp1_err   = rsp_err[1];

  // ALU inputs come straight from the operand latch so they hold outside EXEC.
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_ctl = ctl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      owner   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q     <= req_a[gnt];
          b_q     <= req_b[gnt];
          ctl_q   <= ctl_norm[gnt];
          err_q   <= ctl_bad[gnt];
          owner   <= gnt;
          rr_last <= gnt;
          state   <= EXEC;
        end
        EXEC: begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          state  <= RESP;
        end
        RESP: if (rsp_ready[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
